// File: rtl/pwm_ramp_scheduler.sv
// Steps each PWM channel's threshold toward its commanded target one LSB at a time,
// and serialises the resulting threshold writes onto the shared PWM bank bus.
module pwm_ramp_scheduler #(
  parameter int pwm_width  = 8,
  parameter int num_pwm    = 12,
  parameter int rate_width = 8,
  localparam int chan_bits = (num_pwm > 1) ? $clog2(num_pwm) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  overflow,
  input  logic                  cmd_valid,
  input  logic [chan_bits-1:0]  cmd_chan,
  input  logic [pwm_width-1:0]  cmd_target,
  input  logic [rate_width-1:0] cmd_rate,
  output logic [pwm_width-1:0]  new_thres,
  output logic [num_pwm-1:0]    set_thres,
  output logic [num_pwm-1:0]    busy
);

  logic [pwm_width-1:0]  cur_r  [num_pwm];
  logic [pwm_width-1:0]  tgt_r  [num_pwm];
  logic [rate_width-1:0] rate_r [num_pwm];
  logic [rate_width-1:0] tick_r [num_pwm];
  logic [num_pwm-1:0]    pend_r;
  logic [chan_bits-1:0]  last_r;
  logic [pwm_width-1:0]  new_thres_r;
  logic [num_pwm-1:0]    set_thres_r;

  logic [num_pwm-1:0]    cmd_hit_s;
  logic [num_pwm-1:0]    tick_ev_s;
  logic [num_pwm-1:0]    reload_s;
  logic [num_pwm-1:0]    grant_s;
  logic                  grant_vld_s;
  logic [chan_bits-1:0]  grant_idx_s;
  logic [chan_bits:0]    cand_s;
  logic [pwm_width-1:0]  cur_nxt_s [num_pwm];
  logic [pwm_width-1:0]  wr_val_s;

  assign new_thres = new_thres_r;
  assign set_thres = set_thres_r;

  // Round-robin search for the first pending channel after the last one served.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_idx_s = '0;
    cand_s      = '0;
    for (int k = 1; k <= num_pwm; k++) begin
      cand_s = {1'b0, last_r} + (chan_bits+1)'(k);
      if (cand_s >= (chan_bits+1)'(num_pwm)) begin
        cand_s = cand_s - (chan_bits+1)'(num_pwm);
      end else begin
        cand_s = cand_s;
      end
      if (!grant_vld_s && pend_r[cand_s[chan_bits-1:0]]) begin
        grant_vld_s = 1'b1;
        grant_idx_s = cand_s[chan_bits-1:0];
      end else begin
        grant_vld_s = grant_vld_s;
      end
    end
  end

  // Per-channel decode: command hit, period tick, grant and the stepped duty value.
  always_comb begin
    wr_val_s = '0;
    for (int i = 0; i < num_pwm; i++) begin
      cmd_hit_s[i] = cmd_valid && (cmd_chan == chan_bits'(i));
      // A command to the same channel takes precedence over the period tick.
      tick_ev_s[i] = overflow && (cur_r[i] != tgt_r[i]) &&
                     (rate_r[i] != '0) && !cmd_hit_s[i];
      reload_s[i]  = (tick_r[i] <= rate_width'(1));
      grant_s[i]   = grant_vld_s && (grant_idx_s == chan_bits'(i));
      busy[i]      = (cur_r[i] != tgt_r[i]);
      if (!grant_s[i]) begin
        cur_nxt_s[i] = cur_r[i];
      end else if (rate_r[i] == '0) begin
        cur_nxt_s[i] = tgt_r[i];
      end else if (cur_r[i] < tgt_r[i]) begin
        cur_nxt_s[i] = cur_r[i] + pwm_width'(1);
      end else if (cur_r[i] > tgt_r[i]) begin
        cur_nxt_s[i] = cur_r[i] - pwm_width'(1);
      end else begin
        cur_nxt_s[i] = cur_r[i];
      end
      if (grant_s[i]) begin
        wr_val_s = cur_nxt_s[i];
      end else begin
        wr_val_s = wr_val_s;
      end
    end
  end

  // Channel state, arbitration pointer and the registered write strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < num_pwm; i++) begin
        cur_r[i]  <= '0;
        tgt_r[i]  <= '0;
        rate_r[i] <= '0;
        tick_r[i] <= '0;
      end
      pend_r      <= '0;
      last_r      <= chan_bits'(num_pwm - 1);
      new_thres_r <= '0;
      set_thres_r <= '0;
    end else begin
      for (int i = 0; i < num_pwm; i++) begin
        cur_r[i] <= cur_nxt_s[i];
        if (cmd_hit_s[i]) begin
          tgt_r[i]  <= cmd_target;
          rate_r[i] <= cmd_rate;
          tick_r[i] <= cmd_rate;
          pend_r[i] <= (cmd_rate == '0) ? 1'b1 : (pend_r[i] && !grant_s[i]);
        end else if (tick_ev_s[i]) begin
          tick_r[i] <= reload_s[i] ? rate_r[i] : (tick_r[i] - rate_width'(1));
          pend_r[i] <= reload_s[i] ? 1'b1 : (pend_r[i] && !grant_s[i]);
        end else begin
          pend_r[i] <= pend_r[i] && !grant_s[i];
        end
      end
      if (grant_vld_s) begin
        last_r      <= grant_idx_s;
        new_thres_r <= wr_val_s;
      end else begin
        last_r      <= last_r;
        new_thres_r <= new_thres_r;
      end
      set_thres_r <= grant_s;
    end
  end

endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Directed bench for pwm_ramp_scheduler: jump, ramp up/down, contention,
// retargeting, illegal channel and mid-ramp reset.
module tb_pwm_ramp_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        overflow;
  logic        cmd_valid;
  logic [3:0]  cmd_chan;
  logic [7:0]  cmd_target;
  logic [7:0]  cmd_rate;
  logic [7:0]  new_thres;
  logic [11:0] set_thres;
  logic [11:0] busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int strobe_cnt = 0;
  int multi_cnt = 0;

  pwm_ramp_scheduler #(.pwm_width(8), .num_pwm(12), .rate_width(8)) dut (
    .clk(clk), .reset(reset), .overflow(overflow),
    .cmd_valid(cmd_valid), .cmd_chan(cmd_chan), .cmd_target(cmd_target),
    .cmd_rate(cmd_rate), .new_thres(new_thres), .set_thres(set_thres), .busy(busy)
  );

  always #5 clk = ~clk;

  // Strobe monitor, sampled between edges.
  always @(posedge clk) begin
    #2;
    if (set_thres != 12'h000) strobe_cnt++;
    if ($countones(set_thres) > 1) multi_cnt++;
  end

  task automatic send_cmd(input logic [3:0] ch, input logic [7:0] tg, input logic [7:0] rt);
    cmd_valid = 1'b1; cmd_chan = ch; cmd_target = tg; cmd_rate = rt;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic pulse_ovf();
    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; overflow = 1'b0; cmd_valid = 1'b0;
    cmd_chan = 4'd0; cmd_target = 8'd0; cmd_rate = 8'd0;
    repeat (3) @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h000 || new_thres !== 8'h00 || busy !== 12'h000) begin
      $display("FAIL reset_state: set=%h thres=%h busy=%h want 000/00/000", set_thres, new_thres, busy);
      err_cnt++;
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_jump();
    send_cmd(4'd3, 8'h40, 8'd0);
    vec_cnt++;
    if (set_thres !== 12'h000 || busy !== 12'h008) begin
      $display("FAIL jump_t1: set=%h busy=%h want 000/008", set_thres, busy);
      err_cnt++;
    end
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h008 || new_thres !== 8'h40) begin
      $display("FAIL jump_strobe: set=%h thres=%h want 008/40", set_thres, new_thres);
      err_cnt++;
    end
    vec_cnt++;
    if (busy !== 12'h000) begin
      $display("FAIL jump_busy: busy=%h want 000", busy);
      err_cnt++;
    end
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h000 || new_thres !== 8'h40) begin
      $display("FAIL jump_hold: set=%h thres=%h want 000/40", set_thres, new_thres);
      err_cnt++;
    end
  endtask

  task automatic test_ramp_up();
    int s0;
    s0 = strobe_cnt;
    send_cmd(4'd0, 8'd5, 8'd2);
    vec_cnt++;
    if (busy[0] !== 1'b1) begin
      $display("FAIL ramp_up_busy_rise: busy0=%b want 1", busy[0]);
      err_cnt++;
    end
    for (int k = 1; k <= 12; k++) begin
      repeat (254) @(negedge clk);
      pulse_ovf();
      @(negedge clk);
      vec_cnt++;
      if (k % 2 == 0 && k <= 10) begin
        if (set_thres !== 12'h001 || new_thres !== 8'(k / 2)) begin
          $display("FAIL ramp_up_step%0d: set=%h thres=%0d want 001/%0d", k, set_thres, new_thres, k / 2);
          err_cnt++;
        end
      end else if (set_thres !== 12'h000) begin
        $display("FAIL ramp_up_idle%0d: set=%h want 000", k, set_thres);
        err_cnt++;
      end
    end
    vec_cnt++;
    if (strobe_cnt - s0 != 5 || busy[0] !== 1'b0) begin
      $display("FAIL ramp_up_total: strobes=%0d busy0=%b want 5/0", strobe_cnt - s0, busy[0]);
      err_cnt++;
    end
  endtask

  task automatic test_ramp_down();
    send_cmd(4'd1, 8'd10, 8'd0);
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h002 || new_thres !== 8'd10) begin
      $display("FAIL down_jump: set=%h thres=%0d want 002/10", set_thres, new_thres);
      err_cnt++;
    end
    send_cmd(4'd1, 8'd7, 8'd1);
    for (int v = 9; v >= 6; v--) begin
      repeat (3) @(negedge clk);
      pulse_ovf();
      @(negedge clk);
      vec_cnt++;
      if (v >= 7 && (set_thres !== 12'h002 || new_thres !== 8'(v))) begin
        $display("FAIL down_step: set=%h thres=%0d want 002/%0d", set_thres, new_thres, v);
        err_cnt++;
      end else if (v < 7 && set_thres !== 12'h000) begin
        $display("FAIL down_extra: set=%h want 000", set_thres);
        err_cnt++;
      end
    end
  endtask

  task automatic test_contention();
    int ord [3] = '{5, 11, 2};
    send_cmd(4'd4, 8'h20, 8'd0);
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h010) begin
      $display("FAIL cont_last4: set=%h want 010", set_thres);
      err_cnt++;
    end
    send_cmd(4'd5, 8'd1, 8'd1);
    send_cmd(4'd2, 8'd1, 8'd1);
    send_cmd(4'd11, 8'd1, 8'd1);
    pulse_ovf();
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      vec_cnt++;
      if (set_thres !== 12'(1 << ord[j]) || new_thres !== 8'd1) begin
        $display("FAIL cont_order%0d: set=%h thres=%0d want %h/1", j, set_thres, new_thres, 12'(1 << ord[j]));
        err_cnt++;
      end
    end
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h000 || multi_cnt != 0 || busy !== 12'h000) begin
      $display("FAIL cont_after: set=%h multi=%0d busy=%h want 000/0/000", set_thres, multi_cnt, busy);
      err_cnt++;
    end
  endtask

  task automatic test_retarget();
    int s0;
    send_cmd(4'd7, 8'd3, 8'd0);
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h080 || new_thres !== 8'd3) begin
      $display("FAIL retgt_jump: set=%h thres=%0d want 080/3", set_thres, new_thres);
      err_cnt++;
    end
    send_cmd(4'd7, 8'd9, 8'd1);
    send_cmd(4'd7, 8'd1, 8'd1);
    vec_cnt++;
    if (busy !== 12'h080) begin
      $display("FAIL retgt_busy: busy=%h want 080", busy);
      err_cnt++;
    end
    for (int v = 2; v >= 0; v--) begin
      repeat (2) @(negedge clk);
      pulse_ovf();
      @(negedge clk);
      vec_cnt++;
      if (v >= 1 && (set_thres !== 12'h080 || new_thres !== 8'(v))) begin
        $display("FAIL retgt_step: set=%h thres=%0d want 080/%0d", set_thres, new_thres, v);
        err_cnt++;
      end else if (v == 0 && (set_thres !== 12'h000 || busy !== 12'h000)) begin
        $display("FAIL retgt_done: set=%h busy=%h want 000/000", set_thres, busy);
        err_cnt++;
      end
    end
    s0 = strobe_cnt;
    send_cmd(4'd12, 8'h55, 8'd0);
    repeat (3) @(negedge clk);
    pulse_ovf();
    repeat (2) @(negedge clk);
    vec_cnt++;
    if (strobe_cnt != s0 || busy !== 12'h000 || new_thres !== 8'd1) begin
      $display("FAIL illegal_chan: strobes=%0d busy=%h thres=%0d want 0/000/1", strobe_cnt - s0, busy, new_thres);
      err_cnt++;
    end
  endtask

  task automatic test_reset_mid_ramp();
    send_cmd(4'd6, 8'd50, 8'd1);
    vec_cnt++;
    if (busy !== 12'h040) begin
      $display("FAIL rst_mid_busy: busy=%h want 040", busy);
      err_cnt++;
    end
    pulse_ovf();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    vec_cnt++;
    if (set_thres !== 12'h000 || busy !== 12'h000 || new_thres !== 8'h00) begin
      $display("FAIL rst_mid_clear: set=%h busy=%h thres=%h want 000/000/00", set_thres, busy, new_thres);
      err_cnt++;
    end
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h000) begin
      $display("FAIL rst_mid_nostrobe: set=%h want 000", set_thres);
      err_cnt++;
    end
    send_cmd(4'd3, 8'h40, 8'd0);
    vec_cnt++;
    if (set_thres !== 12'h000) begin
      $display("FAIL rst_mid_t1: set=%h want 000", set_thres);
      err_cnt++;
    end
    @(negedge clk);
    vec_cnt++;
    if (set_thres !== 12'h008 || new_thres !== 8'h40 || busy !== 12'h000) begin
      $display("FAIL rst_mid_cmd: set=%h thres=%h busy=%h want 008/40/000", set_thres, new_thres, busy);
      err_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_jump();
    test_ramp_up();
    test_ramp_down();
    test_contention();
    test_retarget();
    test_reset_mid_ramp();
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
